// File: rtl/rename_commit_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rename_commit_seq_pkg
//  Description : Shared defaults and sequencer state encoding for the rename
//                free-list sequencer, its bus interface and the rename stage.
//  Revision    : 1.0
// ============================================================================
package rename_commit_seq_pkg;

   localparam int c_name_w = 6;
   localparam int c_depth  = 16;
   localparam int c_tag_w  = 4;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ACK   = 2'd2
   } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/rename_commit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : rename_commit_seq_if
//  Description : Allocation / completion / free / drain bus between the rename
//                stage (master) and the commit sequencer (slave).
//  Revision    : 1.0
// ============================================================================
interface rename_commit_seq_if
   import rename_commit_seq_pkg::*;
#(
   parameter int NAME_W = c_name_w,
   parameter int TAG_W  = c_tag_w
);

   logic              ALLOC_E;
   logic [NAME_W-1:0] ALLOC_NAME;
   logic              ENQ_READY;
   logic [TAG_W-1:0]  TAG_OUT;
   logic              DONE_E;
   logic [TAG_W-1:0]  DONE_TAG;
   logic              FE;
   logic [NAME_W-1:0] NAME_F;
   logic              DRAIN_REQ;
   logic              DRAIN_ACK;
   logic [TAG_W:0]    COUNT;

   modport master (
      output ALLOC_E, ALLOC_NAME, DONE_E, DONE_TAG, DRAIN_REQ,
      input  ENQ_READY, TAG_OUT, FE, NAME_F, DRAIN_ACK, COUNT
   );

   modport slave (
      input  ALLOC_E, ALLOC_NAME, DONE_E, DONE_TAG, DRAIN_REQ,
      output ENQ_READY, TAG_OUT, FE, NAME_F, DRAIN_ACK, COUNT
   );

endinterface
`default_nettype wire

// File: rtl/rename_commit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rename_commit_seq
//  Description : In-order free-list sequencer: records allocations, tracks
//                writeback, frees names strictly in allocation order, drains.
//  Revision    : 1.0
// ============================================================================
module rename_commit_seq
   import rename_commit_seq_pkg::*;
#(
   parameter int NAME_W = c_name_w,
   parameter int DEPTH  = c_depth,
   parameter int TAG_W  = $clog2(DEPTH)
) (
   input  wire logic          CLK,
   input  wire logic          RST,
   rename_commit_seq_if.slave bus
);

   localparam logic [TAG_W:0]   c_full     = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W-1:0] c_ptr_one  = TAG_W'(1);
   localparam logic [TAG_W:0]   c_cnt_zero = '0;

   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  r_done;
   logic [NAME_W-1:0] r_name [DEPTH];
   logic [TAG_W-1:0]  r_head;
   logic [TAG_W-1:0]  r_tail;
   logic [TAG_W:0]    r_count;

   seq_state_e        r_state;
   seq_state_e        w_state_nxt;
   logic              r_acked;
   logic              w_acked_nxt;

   logic              w_enq_ready;
   logic              w_enq;
   logic              w_ret;
   logic              w_empty;
   logic [TAG_W:0]    w_count_nxt;

   assign w_enq_ready = (r_count < c_full) && (r_state == ST_RUN);
   assign w_enq       = bus.ALLOC_E && w_enq_ready;
   // Head blocks: only the oldest entry may retire, and only once complete.
   assign w_ret       = r_valid[r_head] && r_done[r_head];
   assign w_empty     = (r_count == c_cnt_zero);
   assign w_count_nxt = r_count + {{TAG_W{1'b0}}, w_enq} - {{TAG_W{1'b0}}, w_ret};

   assign bus.ENQ_READY = w_enq_ready;
   assign bus.TAG_OUT   = r_tail;
   assign bus.FE        = w_ret;
   assign bus.NAME_F    = w_ret ? r_name[r_head] : '0;
   assign bus.DRAIN_ACK = (r_state == ST_ACK);
   assign bus.COUNT     = r_count;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_valid <= '0;
         r_done  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_name[i] <= '0;
         end
      end else begin
         if (w_enq) begin
            r_valid[r_tail] <= 1'b1;
            r_done[r_tail]  <= 1'b0;
            r_name[r_tail]  <= bus.ALLOC_NAME;
            r_tail          <= r_tail + c_ptr_one;
         end
         if (bus.DONE_E && r_valid[bus.DONE_TAG]) begin
            r_done[bus.DONE_TAG] <= 1'b1;
         end
         // Retire is written last so it wins over a redundant completion of head.
         if (w_ret) begin
            r_valid[r_head] <= 1'b0;
            r_done[r_head]  <= 1'b0;
            r_head          <= r_head + c_ptr_one;
         end
         r_count <= w_count_nxt;
         assert (w_count_nxt <= c_full);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_RUN;
         r_acked <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acked <= w_acked_nxt;
      end
   end

   // r_acked marks the DRAIN that follows an ACK: no second pulse until the
   // request is dropped, and that drop is what returns the sequencer to RUN.
   always_comb begin
      w_state_nxt = r_state;
      w_acked_nxt = r_acked;
      case (r_state)
         ST_RUN: begin
            if (bus.DRAIN_REQ) begin
               w_state_nxt = ST_DRAIN;
               w_acked_nxt = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (r_acked) begin
               if (!bus.DRAIN_REQ && w_empty) begin
                  w_state_nxt = ST_RUN;
                  w_acked_nxt = 1'b0;
               end
            end else if (w_empty) begin
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            if (bus.DRAIN_REQ) begin
               w_state_nxt = ST_DRAIN;
               w_acked_nxt = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
               w_acked_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_acked_nxt = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_rename_commit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rename_commit_seq
//  Description : Scoreboard bench for rename_commit_seq (depth 16, 6-bit names).
//  Revision    : 1.0
// ============================================================================
module tb_rename_commit_seq;

   logic       CLK = 1'b0;
   logic       RST;
   int         n_total = 0;
   int         n_bad   = 0;
   logic [5:0] exp_q[$];
   logic [3:0] m_tail;

   rename_commit_seq_if #(.NAME_W(6), .TAG_W(4)) bus ();

   rename_commit_seq #(.NAME_W(6), .DEPTH(16), .TAG_W(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic alloc(input logic [5:0] nm);
      chk("tag_out", 32'(bus.TAG_OUT), 32'(m_tail));
      bus.ALLOC_E    = 1'b1;
      bus.ALLOC_NAME = nm;
      exp_q.push_back(nm);
      m_tail++;
      tick();
      bus.ALLOC_E = 1'b0;
   endtask

   task automatic done(input logic [3:0] t);
      bus.DONE_E   = 1'b1;
      bus.DONE_TAG = t;
      tick();
      bus.DONE_E = 1'b0;
   endtask

   task automatic do_reset();
      #1 RST = 1'b0;
      #1;
      exp_q.delete();
      m_tail        = '0;
      bus.ALLOC_E   = 1'b0;
      bus.DONE_E    = 1'b0;
      bus.DRAIN_REQ = 1'b0;
      @(negedge CLK);
      #2 RST = 1'b1;
      tick();
   endtask

   // Every free is compared against the allocation order; idle NAME_F must be 0.
   always @(negedge CLK) begin
      if (bus.FE) begin
         if (exp_q.size() == 0) chk("fe_unexpected", 32'(bus.NAME_F), 32'hFFFF_FFFF);
         else                   chk("name_f", 32'(bus.NAME_F), 32'(exp_q.pop_front()));
      end else begin
         chk("name_f_idle", 32'(bus.NAME_F), 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      RST            = 1'b0;
      bus.ALLOC_E    = 1'b0;
      bus.ALLOC_NAME = '0;
      bus.DONE_E     = 1'b0;
      bus.DONE_TAG   = '0;
      bus.DRAIN_REQ  = 1'b0;
      m_tail         = '0;

      // 1. reset state
      #1;
      chk("rst_ready", 32'(bus.ENQ_READY), 1);
      chk("rst_count", 32'(bus.COUNT), 0);
      chk("rst_fe",    32'(bus.FE), 0);
      chk("rst_tag",   32'(bus.TAG_OUT), 0);
      chk("rst_ack",   32'(bus.DRAIN_ACK), 0);
      #12 RST = 1'b1;
      tick();
      chk("post_rst_ready", 32'(bus.ENQ_READY), 1);
      chk("post_rst_count", 32'(bus.COUNT), 0);

      // 2. in-order completion
      alloc(6'd20); alloc(6'd21); alloc(6'd22);
      chk("t2_count", 32'(bus.COUNT), 3);
      chk("t2_fe_idle", 32'(bus.FE), 0);
      for (int k = 0; k < 3; k++) begin
         bus.DONE_E   = 1'b1;
         bus.DONE_TAG = 4'(k);
         tick();
         @(negedge CLK);
         chk("t2_fe", 32'(bus.FE), 1);
      end
      bus.DONE_E = 1'b0;
      tick();
      chk("t2_empty", 32'(bus.COUNT), 0);
      chk("t2_fe_end", 32'(bus.FE), 0);

      // 3. out-of-order completion, head blocks
      do_reset();
      alloc(6'd5); alloc(6'd6); alloc(6'd7);
      done(4'd2);
      done(4'd1);
      @(negedge CLK);
      chk("t3_block_fe", 32'(bus.FE), 0);
      tick();
      chk("t3_block_count", 32'(bus.COUNT), 3);
      done(4'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("t3_fe", 32'(bus.FE), 1);
      end
      tick();
      chk("t3_empty", 32'(bus.COUNT), 0);

      // 4. full and wrap
      do_reset();
      for (int i = 0; i < 16; i++) alloc(6'(8 + i));
      chk("t4_full_ready", 32'(bus.ENQ_READY), 0);
      chk("t4_full_count", 32'(bus.COUNT), 16);
      chk("t4_full_tag",   32'(bus.TAG_OUT), 0);
      bus.ALLOC_E    = 1'b1;
      bus.ALLOC_NAME = 6'd63;
      tick();
      bus.ALLOC_E = 1'b0;
      chk("t4_ignored_count", 32'(bus.COUNT), 16);
      done(4'd0);
      chk("t4_ret_fe",    32'(bus.FE), 1);
      chk("t4_ret_ready", 32'(bus.ENQ_READY), 0);
      tick();
      chk("t4_after_ready", 32'(bus.ENQ_READY), 1);
      chk("t4_after_count", 32'(bus.COUNT), 15);
      alloc(6'd42);
      chk("t4_refill_count", 32'(bus.COUNT), 16);
      chk("t4_refill_ready", 32'(bus.ENQ_READY), 0);

      // 5. drain with pending entries, then drain while already empty
      do_reset();
      alloc(6'd30); alloc(6'd31); alloc(6'd32);
      bus.DRAIN_REQ = 1'b1;
      tick();
      chk("t5_ready_off", 32'(bus.ENQ_READY), 0);
      done(4'd0); done(4'd1); done(4'd2);
      guard = 0;
      @(negedge CLK);
      while (bus.COUNT != 0 && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 50) chk("t5_count_timeout", 32'(guard), 0);
      chk("t5_ack_early", 32'(bus.DRAIN_ACK), 0);
      @(negedge CLK);
      chk("t5_ack", 32'(bus.DRAIN_ACK), 1);
      @(negedge CLK);
      chk("t5_ack_once", 32'(bus.DRAIN_ACK), 0);
      @(negedge CLK);
      chk("t5_ack_held", 32'(bus.DRAIN_ACK), 0);
      chk("t5_ready_held", 32'(bus.ENQ_READY), 0);
      bus.DRAIN_REQ = 1'b0;
      tick();
      chk("t5_ready_back", 32'(bus.ENQ_READY), 1);
      bus.DRAIN_REQ = 1'b1;
      tick();
      chk("t5e_ack_wait", 32'(bus.DRAIN_ACK), 0);
      tick();
      chk("t5e_ack", 32'(bus.DRAIN_ACK), 1);
      bus.DRAIN_REQ = 1'b0;
      tick();
      chk("t5e_ack_off", 32'(bus.DRAIN_ACK), 0);
      chk("t5e_ready", 32'(bus.ENQ_READY), 1);

      // 6. asynchronous reset mid-run with a free pending
      do_reset();
      for (int i = 0; i < 5; i++) alloc(6'(50 + i));
      done(4'd1);
      done(4'd0);
      chk("t6_fe_pre", 32'(bus.FE), 1);
      #1 RST = 1'b0;
      #1;
      chk("t6_fe_rst",    32'(bus.FE), 0);
      chk("t6_count_rst", 32'(bus.COUNT), 0);
      chk("t6_name_rst",  32'(bus.NAME_F), 0);
      chk("t6_tag_rst",   32'(bus.TAG_OUT), 0);
      exp_q.delete();
      m_tail = '0;
      @(negedge CLK);
      #2 RST = 1'b1;
      tick();
      done(4'd0);
      done(4'd1);
      tick();
      chk("t6_fe_after",    32'(bus.FE), 0);
      chk("t6_count_after", 32'(bus.COUNT), 0);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
